// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: CPU redirect, instruction-memory req/ack and CPU-facing head port.
// master = the fetch queue, slave = the CPU/memory environment around it.
interface ifetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        i_valid;
  logic [31:0] i_datain;
  logic [31:0] i_pc;
  logic        i_ready;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, i_ready,
    output imem_req, imem_addr, i_valid, i_datain, i_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, i_ready,
    input  imem_req, imem_addr, i_valid, i_datain, i_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential prefetch over req/ack into a small FIFO,
// flushed and refetched on a CPU redirect.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  ifetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_addr;
  logic               req_q;
  logic [31:0]        pc_mem   [DEPTH];
  logic [31:0]        word_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               push_c;
  logic               pop_c;
  logic               has_room_c;
  logic [CNT_W-1:0]   count_nxt_c;

  // Redirect suppresses both push and pop; occupancy after this edge decides the next request.
  always_comb begin
    push_c      = (state == REQ) && bus.imem_ack && !bus.redirect;
    pop_c       = (count != '0) && bus.i_ready && !bus.redirect;
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    has_room_c  = count_nxt_c < CNT_W'(DEPTH);
  end

  // Control: fetch FSM, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      // An outstanding request must still complete; its data is thrown away.
      case (state)
        REQ, DROP: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      case (state)
        IDLE: begin
          if (has_room_c) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            fetch_pc <= req_addr + 32'd4;
            if (has_room_c) begin
              req_addr <= req_addr + 32'd4;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && push_c) begin
      pc_mem[wr_ptr]   <= req_addr;
      word_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_comb begin
    bus.imem_req  = req_q;
    bus.imem_addr = req_addr;
    bus.i_valid   = (count != '0);
    bus.i_datain  = (count != '0) ? word_mem[rd_ptr] : 32'h0;
    bus.i_pc      = (count != '0) ? pc_mem[rd_ptr]   : 32'h0;
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: memory answers addr+0x100, a scoreboard monitor checks
// every consumed head word against the expected {pc, word} queue.
module tb_ifetch_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic hold;
  int   ack_count;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: zero-wait unless held; data is address + 0x100.
  always_comb begin
    bus.imem_ack   = bus.imem_req && !hold;
    bus.imem_rdata = bus.imem_req ? (bus.imem_addr + 32'h100) : 32'h0;
  end

  always @(posedge clk) begin
    if (reset) ack_count <= 0;
    else if (bus.imem_req && bus.imem_ack) ack_count <= ack_count + 1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = pc + 32'h100;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d words left unconsumed, expected 0", name, exp_q.size());
    end
  endtask

  // Returns 1 ns after the negedge at which a request for address a is visible.
  task automatic wait_addr(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req && bus.imem_addr == a) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_addr: got addr %h req %b, expected request at %h", bus.imem_addr, bus.imem_req, a);
    end
  endtask

  task automatic do_reset(input string prev);
    @(negedge clk);
    reset           = 1'b1;
    bus.i_ready     = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    hold            = 1'b0;
    check_drained(prev);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: samples after stimulus settles, before the consuming edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus.i_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got pc %h word %h, expected no consumption", bus.i_pc, bus.i_datain);
        end else begin
          e = exp_q.pop_front();
          if (bus.i_pc !== e.pc || bus.i_datain !== e.word) begin
            errors++;
            $display("FAIL head_word: got pc %h word %h, expected pc %h word %h",
                     bus.i_pc, bus.i_datain, e.pc, e.word);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    hold            = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.i_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check32("rst_req", 32'(bus.imem_req), 32'h0);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_valid", 32'(bus.i_valid), 32'h0);
    check32("rst_datain", bus.i_datain, 32'h0);
    check32("rst_pc", bus.i_pc, 32'h0);

    // Streaming with zero-wait memory, one word per cycle
    for (int i = 0; i < 5; i++) exp_push(32'(i * 4));
    @(negedge clk);
    reset       = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check32("stream_req", 32'(bus.imem_req), 32'h1);
      check32("stream_addr", bus.imem_addr, 32'(i * 4));
    end

    // Fill to DEPTH with no consumer, then a single pop frees one slot
    do_reset("stream_drain");
    repeat (8) @(negedge clk);
    #1;
    check32("full_acks", 32'(ack_count), 32'd4);
    check32("full_req", 32'(bus.imem_req), 32'h0);
    check32("full_head", bus.i_pc, 32'h0);
    exp_push(32'h0);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    #1;
    check32("refill_req", 32'(bus.imem_req), 32'h1);
    check32("refill_addr", bus.imem_addr, 32'h10);
    @(negedge clk);
    #1;
    check32("refill_done_req", 32'(bus.imem_req), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check32("refill_acks", 32'(ack_count), 32'd5);
    check32("refill_head", bus.i_pc, 32'h4);

    // Redirect with a pending, unacked request goes through DROP
    do_reset("full_drain");
    wait_addr(32'h8);
    hold = 1'b1;
    @(negedge clk);
    #1;
    check32("pend_req", 32'(bus.imem_req), 32'h1);
    check32("pend_addr", bus.imem_addr, 32'h8);
    check32("pend_valid", 32'(bus.i_valid), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h400;
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    check32("drop_valid", 32'(bus.i_valid), 32'h0);
    check32("drop_req", 32'(bus.imem_req), 32'h1);
    check32("drop_addr", bus.imem_addr, 32'h8);
    repeat (2) @(negedge clk);
    #1;
    check32("drop_hold_addr", bus.imem_addr, 32'h8);
    hold = 1'b0;
    @(negedge clk);
    #1;
    check32("drop_ack_req", 32'(bus.imem_req), 32'h0);
    check32("drop_ack_valid", 32'(bus.i_valid), 32'h0);
    @(negedge clk);
    #1;
    check32("redir_req", 32'(bus.imem_req), 32'h1);
    check32("redir_addr", bus.imem_addr, 32'h400);
    @(negedge clk);
    #1;
    check32("redir_head_pc", bus.i_pc, 32'h400);
    check32("redir_head_word", bus.i_datain, 32'h500);
    exp_push(32'h400);
    bus.i_ready = 1'b1;

    // Redirect coincident with ack and pop; low address bits ignored
    do_reset("drop_drain");
    wait_addr(32'h8);
    exp_push(32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h803;
    bus.i_ready     = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.i_ready  = 1'b0;
    #1;
    check32("coinc_valid", 32'(bus.i_valid), 32'h0);
    check32("coinc_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    #1;
    check32("coinc_new_req", 32'(bus.imem_req), 32'h1);
    check32("coinc_new_addr", bus.imem_addr, 32'h800);
    @(negedge clk);
    #1;
    check32("coinc_head_pc", bus.i_pc, 32'h800);
    check32("coinc_head_word", bus.i_datain, 32'h900);

    // Push+pop at count 2 holds occupancy; pointers wrap in order
    do_reset("coinc_drain");
    wait_addr(32'h8);
    for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
    bus.i_ready = 1'b1;
    repeat (8) @(negedge clk);
    bus.i_ready = 1'b0;
    #1;
    check32("pp_head", bus.i_pc, 32'h20);
    check32("pp_acks", 32'(ack_count), 32'd10);
    repeat (4) @(negedge clk);
    #1;
    check32("pp_fill_acks", 32'(ack_count), 32'd12);
    check32("pp_fill_req", 32'(bus.imem_req), 32'h0);
    check32("pp_fill_head", bus.i_pc, 32'h20);

    // Reset mid-request with three entries buffered
    do_reset("pp_drain");
    wait_addr(32'hC);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check32("midrst_valid", 32'(bus.i_valid), 32'h0);
    check32("midrst_req", 32'(bus.imem_req), 32'h0);
    check32("midrst_addr", bus.imem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check32("restart_req", 32'(bus.imem_req), 32'h1);
    check32("restart_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    #1;
    check32("restart_head_pc", bus.i_pc, 32'h0);
    check32("restart_head_word", bus.i_datain, 32'h100);

    @(negedge clk);
    #4;
    check_drained("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue sitting directly upstream of the CPU core: it fetches sequential instruction words from instruction memory over a req/ack handshake and buffers them in a small FIFO. It presents the head word on `i_datain`, the word the CPU executes. On a taken branch/jump/jr the CPU redirects the queue, which flushes buffered words and discards any in-flight fetch. This decouples the CPU from variable-latency instruction memory.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clock`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `redirect`  in  1  CPU control-flow change; flush and refetch
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 00)
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  word-aligned fetch address
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  fetched instruction word
- `i_valid`  out  1  queue head holds a valid instruction
- `i_datain`  out  32  head instruction word; 0 while `i_valid`=0
- `i_pc`  out  32  address of head instruction; 0 while `i_valid`=0
- `i_ready`  in  1  CPU consumes head this cycle when `i_valid`=1

## Operation
- State: `fetch_pc` (32), FIFO of `DEPTH` entries {pc, word}, `rd_ptr`/`wr_ptr` (log2 DEPTH, wrap modulo DEPTH), `count` (0..DEPTH), FSM {IDLE, REQ, DROP}.
- `imem_req` = (state==REQ || state==DROP); `imem_addr` = the address latched when the request was issued. Both stay stable until the cycle `imem_ack`=1.
- IDLE: go to REQ with `imem_addr`←`fetch_pc` when `count` < DEPTH (after this edge's pop).
- REQ, `imem_ack`=1, no redirect: push {`imem_addr`, `imem_rdata`}; `fetch_pc`←`imem_addr`+4 (wraps at 2^32). If post-push/pop `count` < DEPTH, stay in REQ with `imem_addr`←`imem_addr`+4 (back-to-back, 1 word/cycle). Otherwise go to IDLE.
- Pop: `i_valid && i_ready` advances `rd_ptr`. Push and pop in the same cycle leave `count` unchanged. Pop on empty is ignored.
- Redirect has priority over push and pop:
  - `count`←0 and both pointers ←0.
  - `fetch_pc`←{`redirect_pc`[31:2],2'b00}.
  - If state==REQ and `imem_ack`=0: go to DROP.
  - If `imem_ack`=1 that cycle: the data is discarded and the FSM goes to IDLE.
  - If IDLE: stays IDLE and issues from the new pc next cycle.
- DROP: the request stays asserted at the stale address. On `imem_ack` the data is discarded and the FSM goes to IDLE. A further redirect while in DROP only updates `fetch_pc`.
- Full: no request is issued while `count`==DEPTH. A request is never issued without a free slot, so an ack never finds the FIFO full.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `i_valid`=0, `i_datain`=0, `i_pc`=0, `count`=0, state IDLE, `fetch_pc`=RESET_PC.
- Reset asserted mid-operation aborts the outstanding request. Memory must tolerate the abandoned request.
- First request: cycle after `reset` deasserts (edge N+1 → `imem_req`=1).
- Zero-wait memory (ack in the same cycle as req): word visible on `i_valid`/`i_datain` one cycle after the ack cycle.
- Redirect at edge E:
  - `i_valid`=0 from E.
  - First new request at E+1 (from IDLE) or one cycle after the stale ack (from DROP).
- `i_datain`/`i_pc` reflect the FIFO head combinationally from registered storage, masked to 0 when empty.

## Test plan
- Reset then zero-wait memory returning addr+0x100; `i_ready`=1 → `imem_addr` 0,4,8,… one per cycle; `i_pc`=0 with `i_datain`=0x100 two cycles after reset release, then 1 word/cycle.
- `i_ready`=0, DEPTH=4 → exactly 4 acks accepted (pc 0..0xC); `imem_req` drops to 0; `count`=4. One pop → a single new request at 0x10.
- Redirect to 0x400 while a request at 0x8 is pending without ack (ack after 3 cycles) → state DROP; stale word discarded; next `imem_addr`=0x400; first `i_pc` after flush =0x400.
- Redirect coincident with ack and pop → queue empty next cycle, acked word not visible, next request at `redirect_pc`; `redirect_pc`=0x803 fetches 0x800.
- Push and pop in the same cycle at `count`=2 → `count` stays 2; pointer wrap after 4 entries preserves order (pc 0x0..0x1C in order).
- Reset asserted while in REQ with 3 entries → `i_valid`=0 and `imem_req`=0 next cycle; fetching restarts from RESET_PC.
